// File: rtl/usart_rx.sv
`default_nettype none
// ============================================================================
// Module   : usart_rx
// Purpose  : Oversampling 8N1 serial receiver with valid/ack holding register,
//            overrun and framing status. Optional parity via USART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module usart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
`ifdef USART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_pin,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_overrun,
  output logic                 rx_frame_error,
`ifdef USART_RX_PARITY_EN
  output logic                 rx_parity_error,
`endif
  output logic                 rx_busy
);

  localparam int c_tick_w = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int c_bit_w  = $clog2(DATA_BITS + 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
  localparam logic [c_tick_w-1:0] c_tick_half = c_tick_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef USART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_sync;
  logic [c_tick_w-1:0]   r_tick_cnt;
  logic [c_tick_w-1:0]   w_tick_nxt;
  logic [c_bit_w-1:0]    r_bit_cnt;
  logic [c_bit_w-1:0]    w_bit_nxt;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  r_frame_error;
  logic                  r_deliver;
  logic                  w_rxs;
  logic                  w_tick_last;
  logic                  w_shift_en;
  logic                  w_stop_good;
  logic                  w_stop_bad;
`ifdef USART_RX_PARITY_EN
  logic                  w_par_sample;
  logic                  w_par_mismatch;
  logic                  r_par_bad;
  logic                  r_parity_error;
`endif

  assign w_rxs       = r_sync[1];
  assign w_tick_last = (r_tick_cnt == c_tick_last);

  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick_cnt;
    w_bit_nxt    = r_bit_cnt;
    w_shift_en   = 1'b0;
    w_stop_good  = 1'b0;
    w_stop_bad   = 1'b0;
`ifdef USART_RX_PARITY_EN
    w_par_sample = 1'b0;
`endif
    if (sample_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rxs) begin
            w_state_nxt = ST_START;
            w_tick_nxt  = '0;
          end
        end
        ST_START: begin
          if (r_tick_cnt == c_tick_half) begin
            w_tick_nxt = '0;
            w_bit_nxt  = '0;
            // A start bit that is high again by mid-bit was only a glitch
            w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
          end else begin
            w_tick_nxt = r_tick_cnt + c_tick_w'(1);
          end
        end
        ST_DATA: begin
          if (w_tick_last) begin
            w_tick_nxt = '0;
            w_shift_en = 1'b1;
            if (r_bit_cnt == c_bit_last) begin
`ifdef USART_RX_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_STOP;
`endif
            end else begin
              w_bit_nxt = r_bit_cnt + c_bit_w'(1);
            end
          end else begin
            w_tick_nxt = r_tick_cnt + c_tick_w'(1);
          end
        end
`ifdef USART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_tick_last) begin
            w_tick_nxt   = '0;
            w_par_sample = 1'b1;
            w_state_nxt  = ST_STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + c_tick_w'(1);
          end
        end
`endif
        ST_STOP: begin
          if (w_tick_last) begin
            w_tick_nxt  = '0;
            w_stop_good = w_rxs;
            w_stop_bad  = !w_rxs;
            w_state_nxt = w_rxs ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            w_tick_nxt = r_tick_cnt + c_tick_w'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (w_rxs) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

`ifdef USART_RX_PARITY_EN
  assign w_par_mismatch = w_rxs ^ (^r_shift) ^ PARITY_ODD;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync        <= 2'b11;
      r_state       <= ST_IDLE;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_deliver     <= 1'b0;
      r_frame_error <= 1'b0;
`ifdef USART_RX_PARITY_EN
      r_par_bad      <= 1'b0;
      r_parity_error <= 1'b0;
`endif
    end else begin
      r_sync     <= {r_sync[0], rx_pin};
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      if (w_shift_en) begin
        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
      end
      r_frame_error <= w_stop_bad;
`ifdef USART_RX_PARITY_EN
      if (w_par_sample) begin
        r_par_bad <= w_par_mismatch;
      end
      r_parity_error <= w_par_sample && w_par_mismatch;
      r_deliver      <= w_stop_good && !r_par_bad;
`else
      r_deliver      <= w_stop_good;
`endif
    end
  end

  // Holding register: a same-cycle ack frees the slot for the arriving byte
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_deliver) begin
      if (!r_valid || rx_ack) begin
        r_data    <= r_shift;
        r_valid   <= 1'b1;
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (rx_ack) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign rx_data        = r_data;
  assign rx_valid       = r_valid;
  assign rx_overrun     = r_overrun;
  assign rx_frame_error = r_frame_error;
  assign rx_busy        = (r_state != ST_IDLE);
`ifdef USART_RX_PARITY_EN
  assign rx_parity_error = r_parity_error;
`endif

endmodule
`default_nettype wire
